adc_sample_reader: RTL and testbench
====================================

ADC_SAMPLE_READER -- requirements
Module: adc_sample_reader

Interface
REQ-001 Parameter DEPTH, 4, result FIFO depth; power of two, 2..16.
REQ-002 Parameter TIMEOUT, 512, max cycles from adc_restart to adc_valid before abort.
REQ-003 Parameter HOLDOFF, 8, idle cycles between conversions (0 allowed).
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: enable  input  1  level; 1 = run back-to-back conversions.
REQ-007 Port: adc_restart  output  1  one-cycle pulse starting an ADC conversion.
REQ-008 Port: adc_busy  input  1  ADC conversion in progress.
REQ-009 Port: adc_valid  input  1  ADC result available (level).
REQ-010 Port: adc_data  input  8  ADC result; meaningful only while adc_valid=1.
REQ-011 Port: out_valid / out_ready / out_data  output / input / output  1 / 1 / 8  result stream, valid-ready.
REQ-012 Port: ovf_count  output  8  samples dropped on full FIFO, saturating.
REQ-013 Port: timeout_err  output  1  sticky; set on any timeout abort.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT_BUSY, CONVERT, HOLD; all outputs registered.
REQ-015 IDLE: enable=1 -> START next cycle; enable=0 -> stay.
REQ-016 START: adc_restart=1 for exactly this one cycle; timeout counter cleared; -> WAIT_BUSY.
REQ-017 WAIT_BUSY: adc_busy=1 -> CONVERT; adc_valid=1 with adc_busy=0 -> capture as in REQ-018, then HOLD.
REQ-018 CONVERT: on first cycle with adc_valid=1, capture adc_data into FIFO that cycle -> HOLD; exactly one capture per conversion.
REQ-019 Timeout counter increments each cycle in WAIT_BUSY/CONVERT; reaching TIMEOUT-1 without capture -> set timeout_err, no capture, -> HOLD.
REQ-020 HOLD SHALL last HOLDOFF cycles (HOLDOFF=0: one cycle), then -> START if enable=1, else IDLE.
REQ-021 enable deasserted mid-conversion SHALL not abort; conversion completes, then IDLE.
REQ-022 Capture with FIFO full SHALL drop the sample and increment ovf_count, saturating at 255; FIFO contents unchanged.
REQ-023 Capture and pop (out_valid & out_ready) in the same cycle with FIFO full SHALL both succeed; no overflow counted.
REQ-024 out_valid = FIFO non-empty; out_data = oldest entry; stable while out_valid=1 and out_ready=0.
REQ-025 First-word latency: captured sample visible on out_data/out_valid the cycle after capture.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-027 Order: out_data SHALL be emitted in capture order, no duplication.

Reset
REQ-028 rst=1 SHALL force IDLE, adc_restart=0, out_valid=0, out_data=0, ovf_count=0, timeout_err=0, FIFO empty, timeout counter 0.
REQ-029 rst mid-conversion SHALL discard the in-flight sample; first adc_restart after release no earlier than 2 cycles after rst falls.
REQ-030 timeout_err and ovf_count SHALL clear only on rst.

Structure
REQ-031 Package adc_reader_pkg SHALL hold the state enum, default DEPTH/TIMEOUT/HOLDOFF and ADC_W=8.
REQ-032 FIFO SHALL be sub-module sample_fifo (DEPTH, width 8, push/pop/full/empty, same clk/rst).
REQ-033 Target size 120-400 RTL lines total.

Verification
REQ-034 enable=1, ADC model busy 3 cycles after restart, valid with data 0x5A 260 cycles later, out_ready=1 -> one adc_restart pulse, out_data=0x5A one cycle after capture, next adc_restart HOLDOFF+1 cycles after capture.
REQ-035 out_ready=0, 6 conversions (0x01..0x06), DEPTH=4 -> FIFO holds 0x01..0x04, ovf_count=2; then out_ready=1 -> emits 0x01..0x04 in order.
REQ-036 ADC never asserts adc_valid -> timeout_err=1 exactly TIMEOUT cycles after adc_restart, no push, next adc_restart issued.
REQ-037 FIFO full with capture and pop same cycle -> ovf_count unchanged, occupancy stays 4, order preserved.
REQ-038 rst pulsed during CONVERT -> all outputs at reset values next cycle, late adc_valid ignored, normal restart after release.
REQ-039 enable dropped during CONVERT -> sample 0xC3 still delivered, no further adc_restart while enable=0.

Source files
------------

// File: rtl/adc_reader_pkg.sv
// Shared types and defaults for the ADC sample reader: FSM state encoding,
// default sizing parameters and the ADC sample width.
package adc_reader_pkg;

  localparam int ADC_W       = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 512;
  localparam int DEF_HOLDOFF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    CONVERT,
    HOLD
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Result FIFO: power-of-two depth, wrapping pointers. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign pop_data = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

endmodule

// File: rtl/adc_sample_reader.sv
// Sequences ADC conversions (restart pulse, busy/valid wait with timeout,
// holdoff) and queues each captured sample into a valid/ready result FIFO.
module adc_sample_reader
  import adc_reader_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             adc_restart,
  input  logic             adc_busy,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADC_W-1:0] out_data,
  output logic [7:0]       ovf_count,
  output logic             timeout_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int HW = $clog2(HOLDOFF + 1) + 1;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_to_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_armed;
  logic          r_restart;
  logic          r_timeout_err;
  logic [7:0]    r_ovf;
  logic          w_in_conv;
  logic          w_capture;
  logic          w_to_hit;
  logic          w_hold_done;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_in_conv   = (r_state == WAIT_BUSY) || (r_state == CONVERT);
  assign w_capture   = adc_valid && (((r_state == WAIT_BUSY) && !adc_busy) ||
                                     (r_state == CONVERT));
  // A capture on the final allowed cycle still wins over the timeout.
  assign w_to_hit    = w_in_conv && !w_capture &&
                       ((r_to_cnt + TW'(1)) == TW'(TIMEOUT - 1));
  assign w_hold_done = (int'(r_hold_cnt) + 1) >= HOLDOFF;
  assign w_pop       = out_ready && !w_empty;
  assign w_drop      = w_capture && w_full && !w_pop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (enable && r_armed) w_next = START;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (w_capture || w_to_hit) w_next = HOLD;
        else if (adc_busy)         w_next = CONVERT;
      end
      CONVERT:   if (w_capture || w_to_hit) w_next = HOLD;
      HOLD:      if (w_hold_done) w_next = enable ? START : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // r_armed delays the first restart after reset release by one extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_armed       <= 1'b0;
      r_restart     <= 1'b0;
      r_to_cnt      <= '0;
      r_hold_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_ovf         <= '0;
    end else begin
      r_state   <= w_next;
      r_armed   <= 1'b1;
      r_restart <= (w_next == START);
      if (r_state == START)  r_to_cnt <= '0;
      else if (w_in_conv)    r_to_cnt <= r_to_cnt + TW'(1);
      if (r_state == HOLD)   r_hold_cnt <= r_hold_cnt + HW'(1);
      else                   r_hold_cnt <= '0;
      if (w_to_hit)          r_timeout_err <= 1'b1;
      if (w_drop)            r_ovf <= sat_inc8(r_ovf);
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_capture),
    .push_data (adc_data),
    .pop       (w_pop),
    .pop_data  (out_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign adc_restart = r_restart;
  assign out_valid   = !w_empty;
  assign ovf_count   = r_ovf;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Bench for adc_sample_reader: a bench-side ADC responds to restart pulses with
// randomized or directed busy/valid timing; a queue-based model tracks results.
module tb_adc_sample_reader;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 512;
  localparam int HOLDOFF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       adc_restart;
  logic       adc_busy;
  logic       adc_valid;
  logic [7:0] adc_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] ovf_count;
  logic       timeout_err;

  always #5 clk = ~clk;

  adc_sample_reader #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .adc_restart (adc_restart),
    .adc_busy    (adc_busy),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .ovf_count   (ovf_count),
    .timeout_err (timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ADC behaviour: one conversion per restart pulse
  bit         a_on = 0;
  int         a_age = 0;
  int         a_busy_at = 1;
  int         a_valid_at = 1;
  bit         a_never = 0;
  logic [7:0] a_sample = '0;
  int         cfg_busy = 0;
  int         cfg_valid = 0;
  bit         cfg_never = 0;
  logic [7:0] plan[$];

  // Reference model
  logic [7:0] mq[$];
  int         m_ovf = 0;
  bit         m_terr = 0;
  bit         m_live = 0;
  bit         m_prev_restart = 0;
  bit         m_rst_seen = 0;
  bit         en_steady = 0;
  int         done_cyc = 0;
  int         restart_cyc = 0;
  int         last_cap_cyc = 0;
  int         caps = 0;
  int         restarts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the effects of the current cycle's inputs to the model.
  task automatic commit();
    bit pop;
    bit cap;
    bit tmo;
    int sz;
    if (rst) begin
      mq.delete();
      m_ovf      = 0;
      m_terr     = 0;
      m_live     = 0;
      en_steady  = 0;
      m_rst_seen = 1;
      return;
    end
    m_rst_seen = 0;
    if (!enable) en_steady = 0;
    sz  = mq.size();
    pop = out_ready && (sz != 0);
    cap = m_live && !a_never && (a_age == a_valid_at);
    tmo = m_live && !cap && (a_age == TIMEOUT - 1);
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (sz < DEPTH || pop) mq.push_back(a_sample);
      else if (m_ovf < 255) m_ovf++;
      caps++;
      last_cap_cyc = cyc;
    end
    if (tmo) m_terr = 1;
    if (cap || tmo) begin
      m_live    = 0;
      done_cyc  = cyc;
      en_steady = enable;
    end
  endtask

  task automatic tick();
    commit();
    @(posedge clk);
    #1;
    cyc++;
    if (en_steady && !m_live && (adc_restart === 1'b1 || cyc == done_cyc + HOLDOFF + 1)) begin
      if (adc_restart === 1'b1) chk("restart_gap", cyc - done_cyc, HOLDOFF + 1);
      else                      chk("restart_due", 32'(adc_restart), 1);
      en_steady = 0;
    end
    if (adc_restart === 1'b1) begin
      chk("restart_single", 32'(m_prev_restart), 0);
      chk("restart_while_busy", 32'(m_live), 0);
      restarts++;
      restart_cyc = cyc;
      m_live = 1;
      a_on   = 1;
      a_age  = 0;
      if (cfg_valid == 0) begin
        a_busy_at  = $urandom_range(1, 4);
        a_valid_at = a_busy_at + $urandom_range(0, 10);
      end else begin
        a_busy_at  = cfg_busy;
        a_valid_at = cfg_valid;
      end
      a_never  = cfg_never;
      a_sample = (plan.size() != 0) ? plan.pop_front() : 8'($urandom);
    end else if (a_on) begin
      a_age++;
    end
    m_prev_restart = (adc_restart === 1'b1);
    adc_busy  = a_on && (a_age >= a_busy_at) && (a_age < a_valid_at);
    adc_valid = a_on && !a_never && (a_age >= a_valid_at);
    adc_data  = adc_valid ? a_sample : 8'($urandom);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("ovf_count", 32'(ovf_count), m_ovf);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (m_rst_seen) begin
      chk("rst_restart", 32'(adc_restart), 0);
      chk("rst_out_data", 32'(out_data), 0);
    end
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic run_caps(input int n, input int budget);
    int lim;
    lim = cyc + budget;
    while (caps < n && cyc < lim) tick();
    chk("capture_seen", 32'(caps >= n), 1);
  endtask

  task automatic wait_restart(input int budget);
    int r;
    int lim;
    r   = restarts;
    lim = cyc + budget;
    while (restarts == r && cyc < lim) tick();
    chk("restart_seen", 32'(restarts != r), 1);
  endtask

  initial begin
    int r0;
    int rs;
    int lim;
    int fall;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    adc_busy = 1'b0; adc_valid = 1'b0; adc_data = '0;

    // Reset state
    run(3);
    chk("reset_restart", 32'(adc_restart), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_ovf", 32'(ovf_count), 0);
    chk("reset_terr", 32'(timeout_err), 0);
    rst = 1'b0;
    run(2);

    // Long conversion: busy at +3, valid 260 cycles later
    cfg_busy = 3; cfg_valid = 263;
    plan.push_back(8'h5A);
    out_ready = 1'b1; enable = 1'b1;
    run_caps(1, 600);
    chk("s1_one_pulse", restarts, 1);
    chk("s1_first_word_valid", 32'(out_valid), 1);
    chk("s1_first_word", 32'(out_data), 32'h5A);
    wait_restart(HOLDOFF + 4);
    chk("s1_next_restart", restart_cyc - last_cap_cyc, HOLDOFF + 1);
    enable = 1'b0;
    run_caps(2, 600);
    run(HOLDOFF + 4);

    // Overflow: six samples with no consumer
    cfg_valid = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) plan.push_back(8'(i));
    enable = 1'b1;
    run_caps(caps + 6, 300);
    enable = 1'b0;
    run(HOLDOFF + 4);
    chk("s2_ovf", 32'(ovf_count), 2);
    chk("s2_full_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("s2_order", 32'(out_data), i);
      tick();
    end
    chk("s2_drained", 32'(out_valid), 0);

    // Full FIFO with capture and pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) plan.push_back(8'(8'h11 + i));
    enable = 1'b1;
    run_caps(caps + 4, 200);
    enable = 1'b0;
    run(HOLDOFF + 4);
    cfg_busy = 2; cfg_valid = 6;
    plan.push_back(8'h15);
    enable = 1'b1;
    wait_restart(10);
    enable = 1'b0;
    lim = cyc + 20;
    while (a_age != a_valid_at && cyc < lim) tick();
    chk("s3_capture_cycle", a_age, a_valid_at);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s3_ovf_unchanged", 32'(ovf_count), 2);
    run(2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s3_order", 32'(out_data), 32'(8'h12 + i));
      tick();
    end
    chk("s3_drained", 32'(out_valid), 0);

    // Timeout: ADC never reports valid
    cfg_never = 1; cfg_busy = 2; cfg_valid = 1000;
    run(HOLDOFF + 2);
    enable = 1'b1;
    wait_restart(10);
    r0  = restart_cyc;
    lim = cyc + TIMEOUT + 20;
    while (timeout_err !== 1'b1 && cyc < lim) tick();
    chk("s4_timeout_lat", cyc - r0, TIMEOUT);
    chk("s4_no_push", 32'(out_valid), 0);
    cfg_never = 0; cfg_valid = 0;
    wait_restart(HOLDOFF + 5);
    chk("s4_next_restart", restart_cyc - r0, TIMEOUT + HOLDOFF);
    enable = 1'b0;
    run_caps(caps + 1, 40);
    chk("s4_terr_sticky", 32'(timeout_err), 1);
    run(HOLDOFF + 4);

    // Enable dropped during CONVERT
    cfg_busy = 3; cfg_valid = 20;
    plan.push_back(8'hC3);
    enable = 1'b1;
    wait_restart(10);
    run(5);
    enable = 1'b0;
    rs = restarts;
    run_caps(caps + 1, 100);
    chk("s5_valid", 32'(out_valid), 1);
    chk("s5_data", 32'(out_data), 32'hC3);
    run(HOLDOFF + 10);
    chk("s5_no_restart", restarts, rs);

    // Reset during CONVERT, late adc_valid ignored, restart after release
    cfg_busy = 3; cfg_valid = 30;
    out_ready = 1'b0;
    enable = 1'b1;
    wait_restart(10);
    run(10);
    rst = 1'b1; enable = 1'b0;
    tick();
    chk("s6_restart", 32'(adc_restart), 0);
    chk("s6_out_valid", 32'(out_valid), 0);
    chk("s6_out_data", 32'(out_data), 0);
    chk("s6_ovf", 32'(ovf_count), 0);
    chk("s6_terr", 32'(timeout_err), 0);
    rst = 1'b0;
    run(35);
    chk("s6_late_ignored", 32'(out_valid), 0);
    rst = 1'b1; enable = 1'b1; cfg_valid = 0;
    tick();
    rst = 1'b0;
    fall = cyc;
    wait_restart(10);
    chk("s6_restart_delay", 32'((restart_cyc - fall) >= 2), 1);
    run_caps(caps + 1, 40);
    chk("s6_normal_capture", 32'(out_valid), 1);
    enable = 1'b0;
    out_ready = 1'b1;
    run(HOLDOFF + 30);
    chk("s6_drained", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
